odd_parity_rx: RTL

- Serial receiver and checker for frames protected by odd parity; the receive-side counterpart of the team's odd-parity generator.
- Frame format: start bit (0), DATA_BITS data bits sent LSB first, one odd-parity bit, stop bit (1). The line idles high.
- The block deserialises each frame, checks parity and stop bit, and presents the byte with error flags to downstream logic as a single-cycle strobe.

---
 rtl/odd_parity_rx.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/odd_parity_rx.sv
// Odd-parity serial receiver: deserialises start/data/parity/stop frames
// and presents each word with parity and framing flags as a one-cycle strobe.
module odd_parity_rx #(
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } state_t;

  state_t               state, state_nxt;
  logic                 rx_q1, rx_s;
  logic [CW-1:0]        clk_cnt, clk_cnt_nxt;
  logic [BW-1:0]        bit_cnt, bit_cnt_nxt;
  logic [DATA_BITS-1:0] shift, shift_nxt;
  logic                 par, par_nxt;
  logic                 stop_bit, stop_nxt;
  logic                 done_q, done_nxt;
  logic [DATA_BITS-1:0] data_out_nxt;
  logic                 data_valid_nxt, parity_err_nxt, frame_err_nxt, busy_nxt;

  // Two-flop synchroniser, reset to the idle line level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_q1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      rx_q1 <= rx;
      rx_s  <= rx_q1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      clk_cnt    <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      par        <= 1'b0;
      stop_bit   <= 1'b0;
      done_q     <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      clk_cnt    <= clk_cnt_nxt;
      bit_cnt    <= bit_cnt_nxt;
      shift      <= shift_nxt;
      par        <= par_nxt;
      stop_bit   <= stop_nxt;
      done_q     <= done_nxt;
      data_out   <= data_out_nxt;
      data_valid <= data_valid_nxt;
      parity_err <= parity_err_nxt;
      frame_err  <= frame_err_nxt;
      busy       <= busy_nxt;
    end
  end

  // Next-state and datapath; done_q delays the strobe one cycle past the stop sample
  always_comb begin
    state_nxt   = state;
    clk_cnt_nxt = clk_cnt + CW'(1);
    bit_cnt_nxt = bit_cnt;
    shift_nxt   = shift;
    par_nxt     = par;
    stop_nxt    = stop_bit;
    done_nxt    = 1'b0;

    case (state)
      IDLE: begin
        clk_cnt_nxt = '0;
        if (!rx_s) state_nxt = START;
      end
      START: begin
        if (clk_cnt == HALF_LAST) begin
          clk_cnt_nxt = '0;
          bit_cnt_nxt = '0;
          state_nxt   = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (clk_cnt == BIT_LAST) begin
          clk_cnt_nxt = '0;
          shift_nxt   = DATA_BITS'({rx_s, shift} >> 1);
          bit_cnt_nxt = bit_cnt + BW'(1);
          if (bit_cnt == DATA_LAST) state_nxt = PARITY;
        end
      end
      PARITY: begin
        if (clk_cnt == BIT_LAST) begin
          clk_cnt_nxt = '0;
          par_nxt     = rx_s;
          state_nxt   = STOP;
        end
      end
      STOP: begin
        if (clk_cnt == BIT_LAST) begin
          clk_cnt_nxt = '0;
          stop_nxt    = rx_s;
          done_nxt    = 1'b1;
          state_nxt   = rx_s ? IDLE : BREAK;
        end
      end
      BREAK: begin
        clk_cnt_nxt = '0;
        if (rx_s) state_nxt = IDLE;
      end
      default: begin
        clk_cnt_nxt = '0;
        state_nxt   = IDLE;
      end
    endcase

    data_out_nxt   = done_q ? shift : data_out;
    data_valid_nxt = done_q;
    parity_err_nxt = done_q & ~(^shift ^ par);
    frame_err_nxt  = done_q & ~stop_bit;
    busy_nxt       = (state_nxt != IDLE);
  end

endmodule
